// File: rtl/aip_proc_core.sv
// aip_proc_core: host-loaded stream processor.
// The host fills MEMIN and four CONF registers, then pulses start. After CONF0
// idle cycles the core streams LENGTH words from MEMIN through the selected
// operation into MEMOUT, then raises done (and int_req when enabled).
//
// Host strobe semantics: write, read and start are single-cycle strobes,
// qualified by en_s and sampled on the rising clock edge. There is no
// back-pressure. Host-side writes that would disturb a running job
// (MEMIN, pointers, CONF) are dropped while busy and flag err. Reads are
// always honoured, and data_out holds the last read value until the next read.
module aip_proc_core #(
  parameter int          DATA_WIDTH = 32,
  parameter int          SIZE_MEM   = 6,
  parameter logic [31:0] IP_ID      = 32'h00001002
) (
  input  logic                  clk,
  input  logic                  rst_a,
  input  logic                  en_s,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  write,
  input  logic                  read,
  input  logic                  start,
  input  logic [4:0]            conf_dbus,
  output logic                  int_req
);

  localparam int DEPTH = 2 ** SIZE_MEM;
  localparam logic [SIZE_MEM:0] FULL_LEN = {1'b1, {SIZE_MEM{1'b0}}};
  localparam logic [SIZE_MEM:0] IDX_ONE  = {{SIZE_MEM{1'b0}}, 1'b1};

  // conf_dbus register/memory selects
  localparam logic [4:0] SEL_MEMIN  = 5'b00000;
  localparam logic [4:0] SEL_PIN    = 5'b00001;
  localparam logic [4:0] SEL_MEMOUT = 5'b00010;
  localparam logic [4:0] SEL_POUT   = 5'b00011;
  localparam logic [4:0] SEL_CONF   = 5'b00100;
  localparam logic [4:0] SEL_PC     = 5'b00101;
  localparam logic [4:0] SEL_CTRL   = 5'b11101;
  localparam logic [4:0] SEL_STATUS = 5'b11110;
  localparam logic [4:0] SEL_ID     = 5'b11111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    RUN   = 2'd2,
    FLUSH = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Storage
  logic [DATA_WIDTH-1:0] memin  [DEPTH];
  logic [DATA_WIDTH-1:0] memout [DEPTH];

  // Host pointers and configuration
  logic [SIZE_MEM-1:0]   pin_q, pout_q;
  logic [1:0]            pc_q;
  logic [DATA_WIDTH-1:0] conf0_q, conf0_n;
  logic [1:0]            conf1_q, conf1_n;
  logic [DATA_WIDTH-1:0] conf2_q, conf2_n;
  logic [SIZE_MEM:0]     conf3_q, conf3_n;

  // Status
  logic done_q, done_d;
  logic err_q, err_d;
  logic int_en_q, int_en_d;
  logic busy;

  // Engine datapath
  logic [DATA_WIDTH-1:0] dly_cnt_q;
  logic [SIZE_MEM:0]     idx_q;
  logic [DATA_WIDTH-1:0] pipe_data_q;
  logic [SIZE_MEM-1:0]   pipe_addr_q;
  logic                  pipe_valid_q;

  // Host decode
  logic host_wr, host_rd, host_start;
  logic memin_we, pin_we, pout_we, conf_we, pc_we, ctrl_we, memout_re;
  logic drop_err, start_ok, start_err;

  // Engine control from the FSM output process
  logic run_rd, out_we, set_done;

  // Engine combinational datapath
  logic [SIZE_MEM:0]     len_eff, last_idx;
  logic [DATA_WIDTH-1:0] memin_rd, op_result;
  logic [SIZE_MEM-1:0]   dest_addr;
  logic [31:0]           status_word;

  assign busy = (state_q != IDLE);

  // Qualify host strobes and decide which host writes are accepted or dropped
  always_comb begin
    host_wr    = en_s & write;
    host_rd    = en_s & read;
    host_start = en_s & start;
    memin_we   = host_wr && (conf_dbus == SEL_MEMIN) && !busy;
    pin_we     = host_wr && (conf_dbus == SEL_PIN)   && !busy;
    pout_we    = host_wr && (conf_dbus == SEL_POUT)  && !busy;
    conf_we    = host_wr && (conf_dbus == SEL_CONF)  && !busy;
    pc_we      = host_wr && (conf_dbus == SEL_PC)    && !busy;
    ctrl_we    = host_wr && (conf_dbus == SEL_CTRL);
    memout_re  = host_rd && (conf_dbus == SEL_MEMOUT);
    drop_err   = host_wr && busy &&
                 ((conf_dbus == SEL_MEMIN) || (conf_dbus == SEL_PIN) ||
                  (conf_dbus == SEL_POUT)  || (conf_dbus == SEL_CONF) ||
                  (conf_dbus == SEL_PC));
    start_ok   = host_start && !busy;
    start_err  = host_start && busy;
  end

  // CONF values including this cycle's write, so a start in the same cycle sees them
  always_comb begin
    conf0_n = conf0_q;
    conf1_n = conf1_q;
    conf2_n = conf2_q;
    conf3_n = conf3_q;
    if (conf_we) begin
      case (pc_q)
        2'd0:    conf0_n = data_in;
        2'd1:    conf1_n = data_in[1:0];
        2'd2:    conf2_n = data_in;
        default: conf3_n = data_in[SIZE_MEM:0];
      endcase
    end
  end

  // Effective length, per-word operation and destination address
  always_comb begin
    if ((conf3_q == '0) || (conf3_q > FULL_LEN)) len_eff = FULL_LEN;
    else                                         len_eff = conf3_q;
    last_idx = len_eff - IDX_ONE;
    memin_rd = memin[idx_q[SIZE_MEM-1:0]];
    case (conf1_q)
      2'd1:    op_result = ~memin_rd;
      2'd2:    op_result = memin_rd + conf2_q;
      default: op_result = memin_rd;
    endcase
    if (conf1_q == 2'd3) dest_addr = SIZE_MEM'(last_idx - idx_q);
    else                 dest_addr = idx_q[SIZE_MEM-1:0];
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst_a) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_ok) state_d = (conf0_n == '0) ? RUN : DELAY;
      end
      DELAY: begin
        if (dly_cnt_q <= DATA_WIDTH'(1)) state_d = RUN;
      end
      RUN: begin
        if (idx_q == last_idx) state_d = FLUSH;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: read MEMIN in RUN, write MEMOUT one word behind, finish in FLUSH
  always_comb begin
    run_rd   = 1'b0;
    out_we   = 1'b0;
    set_done = 1'b0;
    case (state_q)
      RUN: begin
        run_rd = 1'b1;
        out_we = pipe_valid_q;
      end
      FLUSH: begin
        out_we   = 1'b1;
        set_done = 1'b1;
      end
      default: ;
    endcase
  end

  // Next values of the status bits; finishing a job wins over a CTRL clear
  always_comb begin
    done_d = done_q;
    if (ctrl_we && data_in[0]) done_d = 1'b0;
    if (start_ok)              done_d = 1'b0;
    if (set_done)              done_d = 1'b1;
    int_en_d = ctrl_we ? data_in[8] : int_en_q;
    err_d = err_q;
    if (drop_err || start_err) err_d = 1'b1;
    if (start_ok)              err_d = 1'b0;
  end

  // Status, interrupt and configuration registers
  always_ff @(posedge clk) begin
    if (rst_a) begin
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      int_en_q <= 1'b0;
      int_req  <= 1'b0;
      conf0_q  <= '0;
      conf1_q  <= '0;
      conf2_q  <= '0;
      conf3_q  <= '0;
      pc_q     <= '0;
    end else begin
      done_q   <= done_d;
      err_q    <= err_d;
      int_en_q <= int_en_d;
      int_req  <= done_d & int_en_d;
      conf0_q  <= conf0_n;
      conf1_q  <= conf1_n;
      conf2_q  <= conf2_n;
      conf3_q  <= conf3_n;
      if (conf_we)    pc_q <= pc_q + 2'd1;
      else if (pc_we) pc_q <= data_in[1:0];
    end
  end

  // Host memory pointers; both wrap naturally at the memory depth
  always_ff @(posedge clk) begin
    if (rst_a) begin
      pin_q  <= '0;
      pout_q <= '0;
    end else begin
      if (memin_we)    pin_q <= pin_q + SIZE_MEM'(1);
      else if (pin_we) pin_q <= data_in[SIZE_MEM-1:0];
      if (memout_re)    pout_q <= pout_q + SIZE_MEM'(1);
      else if (pout_we) pout_q <= data_in[SIZE_MEM-1:0];
    end
  end

  // Delay counter, read index and the one-stage result pipeline
  always_ff @(posedge clk) begin
    if (rst_a) begin
      dly_cnt_q    <= '0;
      idx_q        <= '0;
      pipe_data_q  <= '0;
      pipe_addr_q  <= '0;
      pipe_valid_q <= 1'b0;
    end else if (start_ok) begin
      dly_cnt_q    <= conf0_n;
      idx_q        <= '0;
      pipe_valid_q <= 1'b0;
    end else begin
      if (state_q == DELAY) dly_cnt_q <= dly_cnt_q - DATA_WIDTH'(1);
      if (run_rd) begin
        pipe_data_q  <= op_result;
        pipe_addr_q  <= dest_addr;
        pipe_valid_q <= 1'b1;
        idx_q        <= idx_q + IDX_ONE;
      end
      if (set_done) pipe_valid_q <= 1'b0;
    end
  end

  // Memory writes (contents are not reset)
  always_ff @(posedge clk) begin
    if (memin_we) memin[pin_q] <= data_in;
    if (out_we)   memout[pipe_addr_q] <= pipe_data_q;
  end

  assign status_word = {23'b0, int_en_q, 5'b0, err_q, busy, done_q};

  // Registered host read port; holds its value between reads
  always_ff @(posedge clk) begin
    if (rst_a) begin
      data_out <= '0;
    end else if (host_rd) begin
      case (conf_dbus)
        SEL_MEMOUT: data_out <= memout[pout_q];
        SEL_STATUS: data_out <= DATA_WIDTH'(status_word);
        SEL_ID:     data_out <= DATA_WIDTH'(IP_ID);
        default:    data_out <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_aip_proc_core.sv
// Self-checking bench for aip_proc_core: host tasks drive one strobe per clock
// edge, read expectations go through a scoreboard queue, and a small reference
// model predicts MEMOUT contents for each job.
module tb_aip_proc_core;

  localparam int DW    = 32;
  localparam int SM    = 6;
  localparam int DEPTH = 64;

  localparam logic [4:0] SEL_MEMIN  = 5'b00000;
  localparam logic [4:0] SEL_PIN    = 5'b00001;
  localparam logic [4:0] SEL_MEMOUT = 5'b00010;
  localparam logic [4:0] SEL_POUT   = 5'b00011;
  localparam logic [4:0] SEL_CONF   = 5'b00100;
  localparam logic [4:0] SEL_PC     = 5'b00101;
  localparam logic [4:0] SEL_CTRL   = 5'b11101;
  localparam logic [4:0] SEL_STATUS = 5'b11110;
  localparam logic [4:0] SEL_ID     = 5'b11111;

  logic          clk = 1'b0;
  logic          rst_a;
  logic          en_s;
  logic [DW-1:0] data_in;
  logic [DW-1:0] data_out;
  logic          write;
  logic          read;
  logic          start;
  logic [4:0]    conf_dbus;
  logic          int_req;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] memin_m  [DEPTH];
  logic [DW-1:0] memout_m [DEPTH];

  // Clock and reset
  always #5 clk = ~clk;

  aip_proc_core #(
    .DATA_WIDTH (DW),
    .SIZE_MEM   (SM),
    .IP_ID      (32'h00001002)
  ) dut (
    .clk       (clk),
    .rst_a     (rst_a),
    .en_s      (en_s),
    .data_in   (data_in),
    .data_out  (data_out),
    .write     (write),
    .read      (read),
    .start     (start),
    .conf_dbus (conf_dbus),
    .int_req   (int_req)
  );

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One host cycle: inputs set at negedge, sampled at the next posedge
  task automatic drive(input logic en, input logic [4:0] sel, input logic [DW-1:0] d,
                       input logic w, input logic r, input logic s,
                       input string tag, input logic [DW-1:0] exp);
    logic [DW-1:0] e;
    @(negedge clk);
    en_s = en; conf_dbus = sel; data_in = d; write = w; read = r; start = s;
    if (r && en) exp_q.push_back(exp);
    @(posedge clk);
    #1;
    write = 1'b0; read = 1'b0; start = 1'b0; en_s = 1'b1;
    if (r && en) begin
      e = exp_q.pop_front();
      check(tag, data_out, e);
    end
  endtask

  task automatic wr(input logic [4:0] sel, input logic [DW-1:0] d);
    drive(1'b1, sel, d, 1'b1, 1'b0, 1'b0, "", '0);
  endtask

  task automatic rd(input logic [4:0] sel, input string tag, input logic [DW-1:0] exp);
    drive(1'b1, sel, '0, 1'b0, 1'b1, 1'b0, tag, exp);
  endtask

  task automatic go();
    drive(1'b1, SEL_MEMIN, '0, 1'b0, 1'b0, 1'b1, "", '0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_conf(input logic [DW-1:0] d, input logic [DW-1:0] mode,
                          input logic [DW-1:0] k, input logic [DW-1:0] len);
    wr(SEL_PC, '0);
    wr(SEL_CONF, d);
    wr(SEL_CONF, mode);
    wr(SEL_CONF, k);
    wr(SEL_CONF, len);
  endtask

  // Reference model of one job's effect on MEMOUT
  task automatic model_run(input logic [1:0] mode, input logic [DW-1:0] k, input logic [DW-1:0] len_raw);
    logic [6:0] lr;
    int l;
    lr = len_raw[6:0];
    l = ((lr == 7'd0) || (lr > 7'd64)) ? 64 : int'(lr);
    for (int i = 0; i < l; i++) begin
      int dst;
      dst = (mode == 2'd3) ? (l - 1 - i) : i;
      case (mode)
        2'd1:    memout_m[dst] = ~memin_m[i];
        2'd2:    memout_m[dst] = memin_m[i] + k;
        default: memout_m[dst] = memin_m[i];
      endcase
    end
  endtask

  task automatic read_memout(input int first, input int n, input string tag);
    wr(SEL_POUT, DW'(first));
    for (int i = 0; i < n; i++) rd(SEL_MEMOUT, tag, memout_m[(first + i) % DEPTH]);
  endtask

  // Status is read at the FLUSH edge (busy) and the edge after (done)
  task automatic wait_job(input int d, input int l, input logic [DW-1:0] extra, input string tag);
    idle(d + l);
    rd(SEL_STATUS, tag, extra | 32'h2);
    rd(SEL_STATUS, tag, extra | 32'h1);
  endtask

  initial begin
    logic [DW-1:0] v;
    rst_a = 1'b1; en_s = 1'b1; write = 1'b0; read = 1'b0; start = 1'b0;
    conf_dbus = '0; data_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_a = 1'b0;

    // Reset state, ID, unmapped read, en_s gating
    check("rst_int_req", DW'(int_req), '0);
    check("rst_data_out", data_out, '0);
    rd(SEL_ID, "id", 32'h00001002);
    rd(5'b01010, "unmapped", '0);
    rd(SEL_STATUS, "rst_status", '0);
    rd(SEL_ID, "id2", 32'h00001002);
    drive(1'b0, SEL_STATUS, '0, 1'b0, 1'b1, 1'b0, "", '0);
    check("en_off_hold", data_out, 32'h00001002);
    drive(1'b0, SEL_MEMIN, '0, 1'b0, 1'b0, 1'b1, "", '0);
    rd(SEL_STATUS, "en_off_start", '0);

    // Full-length copy with no delay
    wr(SEL_PIN, '0);
    for (int i = 0; i < DEPTH; i++) begin
      v = $urandom;
      memin_m[i] = v;
      wr(SEL_MEMIN, v);
    end
    set_conf(0, 0, 0, 0);
    model_run(2'd0, '0, '0);
    go();
    wait_job(0, 64, '0, "copy_status");
    read_memout(0, 64, "copy_out");

    // Long delay, add all-ones, length 8
    wr(SEL_PIN, '0);
    for (int i = 0; i < DEPTH; i++) begin
      memin_m[i] = DW'(i);
      wr(SEL_MEMIN, DW'(i));
    end
    set_conf(1001, 2, 32'hFFFFFFFF, 8);
    model_run(2'd2, 32'hFFFFFFFF, 8);
    go();
    wait_job(1001, 8, '0, "add_status");
    read_memout(0, 64, "add_out");

    // Reverse of four words with interrupt enabled
    wr(SEL_PIN, '0);
    for (int i = 0; i < 4; i++) begin
      v = $urandom;
      memin_m[i] = v;
      wr(SEL_MEMIN, v);
    end
    set_conf(0, 3, 0, 4);
    wr(SEL_CTRL, 32'h100);
    model_run(2'd3, '0, 4);
    go();
    wait_job(0, 4, 32'h100, "rev_status");
    check("rev_int_req", DW'(int_req), 32'h1);
    wr(SEL_CTRL, 32'h001);
    check("ctrl_clr_int_req", DW'(int_req), '0);
    read_memout(0, 8, "rev_out");

    // Start and MEMIN write while busy are dropped and flag err
    set_conf(20, 0, 0, 8);
    model_run(2'd0, '0, 8);
    go();
    drive(1'b1, SEL_MEMIN, 32'hDEADBEEF, 1'b1, 1'b0, 1'b1, "", '0);
    rd(SEL_STATUS, "busy_err_status", 32'h6);
    idle(26);
    rd(SEL_STATUS, "err_flush_status", 32'h6);
    rd(SEL_STATUS, "err_done_status", 32'h5);
    read_memout(0, 8, "err_out");
    v = $urandom;
    memin_m[4] = v;
    wr(SEL_MEMIN, v);

    // Reset during DELAY, then a start that carries a CONF3 write
    set_conf(50, 1, 0, 4);
    go();
    idle(5);
    @(negedge clk);
    rst_a = 1'b1;
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    check("mid_rst_int_req", DW'(int_req), '0);
    rd(SEL_STATUS, "mid_rst_status", '0);
    wr(SEL_PC, 3);
    drive(1'b1, SEL_CONF, 16, 1'b1, 1'b0, 1'b1, "", '0);
    model_run(2'd0, '0, 16);
    wait_job(0, 16, '0, "wstart_status");
    read_memout(0, 16, "wstart_out");

    // Pointer wrap: 65 writes from pin=0, then full copy and a pout wrap read
    wr(SEL_PC, 3);
    wr(SEL_CONF, '0);
    wr(SEL_PIN, '0);
    for (int i = 0; i < DEPTH + 1; i++) begin
      v = $urandom;
      memin_m[i % DEPTH] = v;
      wr(SEL_MEMIN, v);
    end
    model_run(2'd0, '0, '0);
    go();
    wait_job(0, 64, '0, "wrap_status");
    read_memout(0, 64, "wrap_out");
    rd(SEL_MEMOUT, "pout_wrap", memout_m[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/aip_proc_core.md
Name: aip_proc_core

Overview:
- Parametrised successor of the dummy AIP processing core.
- Host loads a MEMIN buffer and a 4-word configuration file through the conf_dbus/write/read/start interface, then pulses start.
- After a programmable delay the core streams LENGTH words from MEMIN through a selectable operation (copy, invert, add-constant, reverse) into MEMOUT.
- It then raises done/int_req.

Parameters:
DATA_WIDTH, 32, data bus and memory word width
SIZE_MEM, 6, log2 of MEMIN/MEMOUT depth (depth = 2**SIZE_MEM)
IP_ID, 32'h00001002, value returned on ID read

Ports:
clk  in  1  system clock
rst_a  in  1  reset; one clock; reset is synchronous and active-high
en_s  in  1  host-access enable; 0 = write/read/start ignored (FSM keeps running)
data_in  in  DATA_WIDTH  host write data
data_out  out  DATA_WIDTH  host read data, registered
write  in  1  write strobe, one cycle, qualified by conf_dbus
read  in  1  read strobe, one cycle, qualified by conf_dbus
start  in  1  start strobe, one cycle
conf_dbus  in  5  register/memory select
int_req  out  1  level interrupt = done & int_en

Behaviour:
- Reset values: data_out=0, int_req=0, all pointers=0, CONF regs=0, done=0, busy=0, err=0, int_en=0, FSM=IDLE. Memory contents are not reset.
- conf_dbus map:
  - 00000 write MEMIN[pin], pin++
  - 00001 write pin=data_in[SIZE_MEM-1:0]
  - 00010 read MEMOUT[pout], pout++
  - 00011 write pout
  - 00100 write CONF[pc], pc++ (mod 4)
  - 00101 write pc=data_in[1:0]
  - 11101 write CTRL: bit0=1 clears done (W1C); bit8 sets int_en
  - 11110 read STATUS = {23'b0, int_en, 5'b0, err, busy, done}
  - 11111 read IP_ID
  - Unmapped codes: no effect; reads return 0.
- Host reads: data_out loads at the rising edge where read=1 and holds until the next read. Memories are async-read arrays.
- Pointer wrap: pin/pout wrap from 2**SIZE_MEM-1 to 0.
- CONF registers:
  - CONF0: delay D (32b)
  - CONF1[1:0]: mode (0 copy, 1 bitwise invert, 2 add CONF2 mod 2**DATA_WIDTH, 3 reverse: out[L-1-i]=in[i])
  - CONF2: constant
  - CONF3[SIZE_MEM:0]: length L; 0 or >2**SIZE_MEM means L=2**SIZE_MEM
- FSM states IDLE, DELAY, RUN, FLUSH:
  - Start sampled at edge N in IDLE: clears done, sets busy. Goes to DELAY with counter=D, or straight to RUN if D=0.
  - DELAY occupies exactly D cycles, then goes to RUN.
  - RUN reads MEMIN[i], i=0..L-1, one per cycle, into a 1-stage pipeline register. Writes MEMOUT for the previous word.
  - FLUSH writes the last word, clears busy, sets done, returns to IDLE.
  - done=1 is visible after edge N+D+L+1.
- int_req = done & int_en, registered. It follows done within one cycle.
- Start while busy: ignored, err=1. MEMIN/CONF/pointer writes while busy: dropped, err=1. MEMOUT and STATUS reads while busy are allowed.
- err clears only on a new accepted start or on reset.
- Simultaneous write and read in the same cycle: both are performed. Simultaneous start with write: the write is performed first, and start is accepted in the same edge with the new CONF values.
- rst_a mid-operation: FSM returns to IDLE; busy/done/err/int_req are 0 next cycle. MEMOUT contents are undefined.
- en_s=0: strobes ignored. No err is set.

Test Plan:
- Reset, read 11111 -> 32'h00001002. Read 11110 -> 0. int_req=0.
- Load 64 random words, CONF0=0, CONF1=0, CONF3=0, start -> done after edge N+65. MEMOUT[0..63] equals MEMIN.
- CONF0=1001, CONF1=2, CONF2=32'hFFFFFFFF, CONF3=8, MEMIN[i]=i -> after N+1010, MEMOUT[i]=i-1 mod 2^32 for i<8. MEMOUT[8..] unchanged.
- CONF1=3, CONF3=4, MEMIN={A,B,C,D}, int_en=1 -> MEMOUT={D,C,B,A}. int_req=1. Write CTRL bit0 -> int_req=0 next cycle.
- Start, then start and a MEMIN write while busy -> STATUS=32'h6 during run. Final output is unaffected by the dropped write.
- Assert rst_a during DELAY -> STATUS=0 and FSM IDLE next cycle. A new start completes normally. Pointer wrap: 65 writes after pin=0 -> MEMIN[0] holds word 65.
